pic_cpu_bus_master: RTL and testbench



---
 rtl/pic_bus_pkg.sv | 28 ++
 rtl/pic_strobe_timer.sv | 33 +++
 rtl/pic_cpu_bus_master.sv | 184 ++++++++++++++++++
 tb/tb_pic_cpu_bus_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_bus_pkg.sv
// Shared types and constants for the 8259 PIC CPU-side bus master.
package pic_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    R_SETUP,
    R_STROBE,
    R_HOLD,
    INTA1,
    INTA_GAP,
    INTA2,
    VEC
  } pic_bus_state_e;

  localparam logic [7:0] BUS_IDLE_Z = 8'hzz;

  // A0 = 0 selects ICW1/OCW2/OCW3, A0 = 1 selects ICW2-4/OCW1/IMR
  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  function automatic int unsigned timer_width(input int unsigned s, input int unsigned g);
    return $clog2(((s > g) ? s : g) + 1);
  endfunction

endpackage

// File: rtl/pic_strobe_timer.sv
// Loadable down-counter shared by every timed bus state; done while the count sits at 1.
module pic_strobe_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/pic_cpu_bus_master.sv
// CPU-side initiator for the 8259 PIC: timed ICW/OCW writes, register reads and
// the two-pulse INTA sequence, with every bus output registered from the next state.
//
// state    | meaning
// IDLE     | bus released, command port ready unless an enabled INT is pending
// W_SETUP  | cs_n low, A0 and write data on the bus
// W_STROBE | wr_n low for STROBE_CYCLES
// W_HOLD   | wr_n high, data still driven, rsp_valid pulse
// R_SETUP  | cs_n low, A0 valid, bus released
// R_STROBE | rd_n low for STROBE_CYCLES, data sampled on the last cycle
// R_HOLD   | rd_n high, rsp_valid pulse with read data
// INTA1    | first inta_n pulse
// INTA_GAP | inta_n high for GAP_CYCLES
// INTA2    | second inta_n pulse, vector sampled on the last cycle
// VEC      | vector_valid held until vector_ready
module pic_cpu_bus_master
  import pic_bus_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       int_enable,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic [7:0] vector,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic       A0,
  inout  wire  [7:0] data_bus,
  output logic       interrupt_acknowledge_n,
  input  logic       interrupt_to_cpu
);

  localparam int unsigned TW = timer_width(STROBE_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] STROBE_LOAD = TW'(STROBE_CYCLES);
  localparam logic [TW-1:0] GAP_LOAD    = TW'(GAP_CYCLES);

  pic_bus_state_e state_q, state_d;

  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_done;
  logic          int_req;

  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       inta_n_q, inta_n_d;
  logic       drive_q, drive_d;
  logic       a0_q, a0_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       vec_valid_q, vec_valid_d;
  logic [7:0] vector_q, vector_d;

  pic_strobe_timer #(.W(TW)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .done_o     (timer_done)
  );

  assign int_req   = int_enable && interrupt_to_cpu;
  assign cmd_ready = reset_n && (state_q == IDLE) && !int_req;

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = STROBE_LOAD;
    case (state_q)
      IDLE: begin
        if (int_req) begin
          state_d    = INTA1;
          timer_load = 1'b1;
        end else if (cmd_valid) begin
          state_d = cmd_write ? W_SETUP : R_SETUP;
        end
      end
      W_SETUP: begin
        state_d    = W_STROBE;
        timer_load = 1'b1;
      end
      W_STROBE: if (timer_done) state_d = W_HOLD;
      W_HOLD:   state_d = IDLE;
      R_SETUP: begin
        state_d    = R_STROBE;
        timer_load = 1'b1;
      end
      R_STROBE: if (timer_done) state_d = R_HOLD;
      R_HOLD:   state_d = IDLE;
      INTA1: begin
        if (timer_done) begin
          state_d    = INTA_GAP;
          timer_load = 1'b1;
          timer_val  = GAP_LOAD;
        end
      end
      INTA_GAP: begin
        if (timer_done) begin
          state_d    = INTA2;
          timer_load = 1'b1;
        end
      end
      INTA2: if (timer_done) state_d = VEC;
      VEC:   if (vector_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_n_d      = !(state_d inside {W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD});
    wr_n_d      = (state_d != W_STROBE);
    rd_n_d      = (state_d != R_STROBE);
    inta_n_d    = !(state_d inside {INTA1, INTA2});
    drive_d     = (state_d inside {W_SETUP, W_STROBE, W_HOLD});
    rsp_valid_d = (state_d inside {W_HOLD, R_HOLD});
    vec_valid_d = (state_d == VEC);

    a0_d       = a0_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    vector_d   = vector_q;
    if (state_q == IDLE && (state_d == W_SETUP || state_d == R_SETUP)) begin
      a0_d    = cmd_a0;
      wdata_d = cmd_data;
    end
    // Samples land on the edge that ends the final strobe cycle
    if (state_q == R_STROBE && timer_done) rsp_data_d = data_bus;
    if (state_q == W_STROBE && timer_done) rsp_data_d = 8'h00;
    if (state_q == INTA2 && timer_done)    vector_d   = data_bus;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      inta_n_q    <= 1'b1;
      drive_q     <= 1'b0;
      a0_q        <= A0_CMD;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      vec_valid_q <= 1'b0;
      vector_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      inta_n_q    <= inta_n_d;
      drive_q     <= drive_d;
      a0_q        <= a0_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      vec_valid_q <= vec_valid_d;
      vector_q    <= vector_d;
    end
  end

  assign chip_select_n           = cs_n_q;
  assign read_enable_n           = rd_n_q;
  assign write_enable_n          = wr_n_q;
  assign interrupt_acknowledge_n = inta_n_q;
  assign A0                      = a0_q;
  assign data_bus                = drive_q ? wdata_q : BUS_IDLE_Z;
  assign rsp_valid               = rsp_valid_q;
  assign rsp_data                = rsp_data_q;
  assign vector_valid            = vec_valid_q;
  assign vector                  = vector_q;

endmodule

// File: tb/tb_pic_cpu_bus_master.sv
// Directed plus randomized bench for pic_cpu_bus_master; a reactive PIC model answers
// reads and INTA, and every cycle is checked against cycle-index timelines.
module tb_pic_cpu_bus_master;
  import pic_bus_pkg::*;

  localparam int S = 2;
  localparam int G = 2;
  localparam logic [7:0] PROBE = 8'h00;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_a0;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       int_enable, vector_valid, vector_ready;
  logic [7:0] vector;
  logic       chip_select_n, read_enable_n, write_enable_n, A0;
  logic       interrupt_acknowledge_n, interrupt_to_cpu;
  wire  [7:0] data_bus;

  logic       tb_oe;
  logic [7:0] tb_val;
  assign data_bus = tb_oe ? tb_val : 8'hzz;

  logic       cur_is_write;
  logic [7:0] rd_val, vec_val;
  logic       inta_prev;
  int         inta_falls;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clock = ~clock;

  pic_cpu_bus_master #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_write               (cmd_write),
    .cmd_a0                  (cmd_a0),
    .cmd_data                (cmd_data),
    .rsp_valid               (rsp_valid),
    .rsp_data                (rsp_data),
    .int_enable              (int_enable),
    .vector_valid            (vector_valid),
    .vector_ready            (vector_ready),
    .vector                  (vector),
    .chip_select_n           (chip_select_n),
    .read_enable_n           (read_enable_n),
    .write_enable_n          (write_enable_n),
    .A0                      (A0),
    .data_bus                (data_bus),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .interrupt_to_cpu        (interrupt_to_cpu)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // PIC side: drive read data under rd_n, probe vs. vector on the two INTA pulses,
  // release the bus while our own write is in flight, otherwise hold a probe value.
  task automatic bus_respond();
    if (inta_prev && !interrupt_acknowledge_n) inta_falls++;
    inta_prev = interrupt_acknowledge_n;
    if (!chip_select_n && !read_enable_n) begin
      tb_oe = 1'b1; tb_val = rd_val;
    end else if (!interrupt_acknowledge_n) begin
      tb_oe = 1'b1; tb_val = inta_falls[0] ? ~vec_val : vec_val;
    end else if (!chip_select_n && cur_is_write) begin
      tb_oe = 1'b0;
    end else begin
      tb_oe = 1'b1; tb_val = PROBE;
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    bus_respond();
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after the command.
  task automatic do_cmd(input logic w, input logic a, input logic [7:0] d,
                        input logic [7:0] rv, input int int_k);
    int waited;
    waited = 0;
    cur_is_write = w;
    rd_val = rv;
    cmd_valid = 1'b1; cmd_write = w; cmd_a0 = a; cmd_data = d;
    while (!cmd_ready && waited < 60) begin
      next_cycle();
      mid();
      waited++;
    end
    chk1("cmd_accept", cmd_ready, 1'b1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    for (int k = 1; k <= S + 3; k++) begin
      next_cycle();
      if (k == 1) cmd_valid = 1'b0;
      if (k == int_k) begin
        interrupt_to_cpu = 1'b1;
        int_enable = 1'b1;
      end
      mid();
      chk1("cs_n", chip_select_n, !(k <= S + 2));
      chk1("wr_n", write_enable_n, !(w && k >= 2 && k <= S + 1));
      chk1("rd_n", read_enable_n, !(!w && k >= 2 && k <= S + 1));
      chk1("inta_n_cmd", interrupt_acknowledge_n, 1'b1);
      chk1("rsp_valid", rsp_valid, k == S + 2);
      if (k <= S + 2) chk1("a0", A0, a);
      if (k == S + 2) chk8("rsp_data", rsp_data, w ? 8'h00 : rv);
      chk8("cmd_bus", data_bus,
           (w && k <= S + 2) ? d : ((!w && k >= 2 && k <= S + 1) ? rv : PROBE));
      chk1("cmd_ready", cmd_ready, (k == S + 3) && !(int_enable && interrupt_to_cpu));
    end
  endtask

  // Called at the negedge of the IDLE cycle in which an enabled INT is present.
  task automatic do_inta(input logic [7:0] v, input logic spurious, input int hold);
    logic in_p1, in_p2, vec_phase;
    int   last;
    last = 2 * S + G + 2 + hold;
    vec_val = v;
    chk1("inta_arb_ready", cmd_ready, 1'b0);
    for (int k = 1; k <= last; k++) begin
      next_cycle();
      if (spurious && k == 2) interrupt_to_cpu = 1'b0;
      if (k == 2 * S + G + 1) interrupt_to_cpu = 1'b0;
      vector_ready = (k == 2 * S + G + 1 + hold);
      mid();
      in_p1     = (k >= 1) && (k <= S);
      in_p2     = (k >= S + G + 1) && (k <= 2 * S + G);
      vec_phase = (k >= 2 * S + G + 1) && (k <= 2 * S + G + 1 + hold);
      chk1("inta_n", interrupt_acknowledge_n, !(in_p1 || in_p2));
      chk1("inta_cs_n", chip_select_n, 1'b1);
      chk1("inta_rd_n", read_enable_n, 1'b1);
      chk1("vector_valid", vector_valid, vec_phase);
      if (vec_phase) chk8("vector", vector, v);
      chk8("inta_bus", data_bus, in_p1 ? ~v : (in_p2 ? v : PROBE));
      chk1("inta_cmd_ready", cmd_ready, k == last);
      chk1("inta_rsp_valid", rsp_valid, 1'b0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic       w, a;
    logic [7:0] d, rv, v;
    int         op;

    tb_oe = 1'b1; tb_val = PROBE;
    cur_is_write = 1'b0; rd_val = 8'h00; vec_val = 8'h00;
    inta_prev = 1'b1; inta_falls = 0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h00;
    int_enable = 1'b0; interrupt_to_cpu = 1'b0; vector_ready = 1'b0;
    reset_n = 1'b0;

    repeat (2) next_cycle();
    mid();
    chk1("rst_cs_n", chip_select_n, 1'b1);
    chk1("rst_rd_n", read_enable_n, 1'b1);
    chk1("rst_wr_n", write_enable_n, 1'b1);
    chk1("rst_inta_n", interrupt_acknowledge_n, 1'b1);
    chk1("rst_a0", A0, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk8("rst_rsp_data", rsp_data, 8'h00);
    chk1("rst_vector_valid", vector_valid, 1'b0);
    chk8("rst_vector", vector, 8'h00);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk8("rst_bus", data_bus, PROBE);
    next_cycle();
    reset_n = 1'b1;
    mid();
    chk1("post_rst_cmd_ready", cmd_ready, 1'b1);

    // ICW1 write, then IMR-style read
    do_cmd(1'b1, A0_CMD, 8'h13, 8'h00, 0);
    do_cmd(1'b0, A0_DATA, 8'hFF, 8'hFB, 0);

    // INT in IDLE
    next_cycle();
    interrupt_to_cpu = 1'b1; int_enable = 1'b1;
    mid();
    do_inta(8'h48, 1'b0, 3);

    // INT raised during the write strobe, with a read queued behind it
    do_cmd(1'b1, A0_DATA, 8'h5A, 8'h00, 2);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_a0 = A0_DATA; cmd_data = 8'hFF;
    do_inta(8'h21, 1'b0, 2);
    do_cmd(1'b0, A0_DATA, 8'hFF, 8'h3C, 0);

    // INT present but disabled
    next_cycle();
    int_enable = 1'b0; interrupt_to_cpu = 1'b1;
    mid();
    do_cmd(1'b1, A0_CMD, 8'h0B, 8'h00, 0);
    do_cmd(1'b0, A0_CMD, 8'hFF, 8'h81, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mid();
      chk1("dis_inta_n", interrupt_acknowledge_n, 1'b1);
      chk1("dis_cmd_ready", cmd_ready, 1'b1);
    end
    next_cycle();
    interrupt_to_cpu = 1'b0;
    mid();

    // Reset during W_STROBE
    chk1("rst_wr_ready", cmd_ready, 1'b1);
    cur_is_write = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_a0 = A0_DATA; cmd_data = 8'hC3;
    next_cycle();
    cmd_valid = 1'b0;
    mid();
    chk1("rst_wr_setup_cs", chip_select_n, 1'b0);
    next_cycle();
    reset_n = 1'b0;
    mid();
    chk1("rst_wr_strobe", write_enable_n, 1'b0);
    next_cycle();
    mid();
    chk1("rst_mid_cs_n", chip_select_n, 1'b1);
    chk1("rst_mid_wr_n", write_enable_n, 1'b1);
    chk1("rst_mid_rd_n", read_enable_n, 1'b1);
    chk1("rst_mid_inta_n", interrupt_acknowledge_n, 1'b1);
    chk1("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk8("rst_mid_bus", data_bus, PROBE);
    chk1("rst_mid_cmd_ready", cmd_ready, 1'b0);
    next_cycle();
    reset_n = 1'b1;
    mid();
    chk1("rst_rel_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rel_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_rel_cs_n", chip_select_n, 1'b1);

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 5));
      w  = 1'($urandom_range(0, 1));
      a  = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(1, 255));
      rv = 8'($urandom_range(0, 254));
      v  = 8'($urandom_range(0, 255));
      if (op <= 3) begin
        do_cmd(w, a, w ? d : 8'hFF, rv, 0);
      end else if (op == 4) begin
        next_cycle();
        interrupt_to_cpu = 1'b1; int_enable = 1'b1;
        mid();
        do_inta(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end else begin
        next_cycle();
        int_enable = 1'b0; interrupt_to_cpu = 1'b1;
        mid();
        do_cmd(w, a, w ? d : 8'hFF, rv, 0);
        next_cycle();
        interrupt_to_cpu = 1'b0;
        mid();
      end
      repeat ($urandom_range(0, 2)) begin
        next_cycle();
        mid();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
